mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multicycle control FSM for the 16-bit RISC datapath. It sequences fetch, decode, execute, memory and writeback over several clocks, and drives the load enables of the register-file write port, the instruction register, the PC and the 2-bit carry/zero flag register. It also drives the datapath mux selects and the memory request handshake. It sits beside the datapath and only reads the instruction register output, the flag register output and the ALU zero result.

## Interface
Parameters:
- MEM_WAIT_MAX, default 15: wait-cycle limit per memory access. Exceeding it raises `timeout`.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  16  instruction register output. opcode = [15:12], cond = [1:0].
- flags  in  2  flag register output: [1] carry, [0] zero.
- alu_zero  in  1  ALU result-is-zero, valid in EXEC.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  store qualifier, valid with mem_req.
- addr_sel  out  1  0 = PC, 1 = ALU out register.
- ir_we, pc_we, rf_we, flag_we  out  1 each  load enables.
- pc_sel  out  2  0 = PC+1, 1 = PC+imm, 2 = reserved (0 driven).
- alu_op  out  2  0 = add, 1 = nand, 2 = sub (compare), 3 = pass-B.
- alu_b_sel  out  1  0 = reg B, 1 = sign-extended imm6.
- wb_sel  out  2  0 = ALU out, 1 = memory data, 2 = PC (link), 3 = imm9<<7.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- timeout  out  1  sticky flag; cleared only by reset.
- busy  out  1  high in every state except RST.

## Operation
- Opcodes: 0000 ADD, 0010 NDU, 0001 ADI, 0011 LHI, 0100 LW, 0101 SW, 1100 BEQ, 1000 JAL. All others are illegal.
- States: RST, FETCH, DECODE, EXEC, MEM, WB, BRANCH.
- RST → FETCH on the first clock after rst_n rises.
- FETCH:
  - Outputs: mem_req=1, addr_sel=0, mem_we=0.
  - When mem_ready=1: ir_we=1, pc_we=1, pc_sel=0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Classify the opcode.
  - Illegal opcode: pulse `illegal`, go to FETCH.
  - JAL: rf_we=1, wb_sel=2, pc_we=1, pc_sel=1, go to FETCH.
  - All other opcodes: go to EXEC.
- EXEC: drive alu_op and alu_b_sel per opcode.
  - ADD, NDU, ADI, LHI → WB.
  - LW, SW → MEM.
  - BEQ: alu_op=2. alu_zero=1 → BRANCH, else FETCH.
- MEM:
  - Outputs: mem_req=1, addr_sel=1, mem_we=1 for SW.
  - On mem_ready: LW → WB, SW → FETCH.
- WB:
  - Always: rf_we=1, then go to FETCH.
  - wb_sel per opcode: ALU ops 0, LW 1, LHI 3.
  - flag_we=1 for ADD, ADI and NDU.
- BRANCH: pc_we=1, pc_sel=1, then go to FETCH.
- Default output value is 0 for every output in every state unless listed above.
- Enables in FETCH and MEM are Mealy (gated by mem_ready). All others are decoded from state plus instr.
- Wait counter:
  - Counts consecutive FETCH/MEM cycles without mem_ready and resets on a state change.
  - Reaching MEM_WAIT_MAX sets `timeout`. The FSM keeps waiting.

## Timing
- Reset (asynchronous, immediate): state=RST, all outputs 0, timeout=0, wait counter=0.
- Latencies, in cycles from FETCH entry with zero-wait memory:
  - ALU op and LHI: 4 (FETCH, DECODE, EXEC, WB).
  - LW: 5. SW: 4.
  - BEQ: 3 not taken, 4 taken.
  - JAL: 2. Illegal opcode: 2.
- Each memory wait cycle adds 1. mem_req is held continuously until the cycle in which mem_ready is seen.
- mem_ready outside FETCH and MEM is ignored.
- rst_n falling mid-access drops mem_req in the same cycle. The partial access is abandoned and there is no replay.
- The conditional-execution skip (see Configuration) applies in EXEC. A skipped instruction takes 3 cycles.

## Configuration
- `MC_CTRL_COND_EXEC_EN`, defined:
  - ADD and NDU honour cond. 00 = always execute, 10 = execute only if carry=1, 01 = execute only if zero=1, 11 = always execute.
  - A failed condition sends EXEC → FETCH with no rf_we and no flag_we.
- Not defined: cond is ignored and ADD/NDU always execute.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum;
  - opcode constants;
  - the alu_op, pc_sel, wb_sel and addr_sel encodings;
  - the flag bit indices.
- Sub-module `mc_ctrl_decode` is purely combinational. It maps opcode and cond to an instruction class and a cond-pass bit, and flags illegal opcodes.
- `mc_ctrl` holds the FSM, the wait counter and the output decode.

## Test plan
- Reset held low, then released with mem_ready=1 and instr=ADD (0x0000) → busy=1, state sequence RST, FETCH, DECODE, EXEC, WB. rf_we=1 and flag_we=1 only in WB, wb_sel=0.
- LW with mem_ready low for 3 MEM cycles → mem_req=1 and addr_sel=1 for 4 cycles, then WB with wb_sel=1. Total 8 cycles.
- BEQ with alu_zero=1, then alu_zero=0 → taken: pc_we=1 and pc_sel=1 in BRANCH, 4 cycles. Not taken: back to FETCH after 3 cycles with no pc_we outside FETCH.
- With the macro defined: ADD cond=10, flags=2'b00 → no rf_we or flag_we, 3 cycles. With flags=2'b10 → full WB.
- Opcode 1111 → illegal pulses for 1 cycle in DECODE, next state FETCH. Then JAL → rf_we=1, wb_sel=2, pc_we=1, pc_sel=1 in DECODE.
- mem_ready held 0 in FETCH for 16 cycles with MEM_WAIT_MAX=15 → timeout rises and stays 1. rst_n pulse → timeout=0 and mem_req=0 immediately.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the mc_ctrl multicycle controller.
// Optional conditional execution is enabled by defining MC_CTRL_COND_EXEC_EN.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RST,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_BRANCH
   } state_e;

   typedef enum logic [3:0] {
      CLS_ADD,
      CLS_NDU,
      CLS_ADI,
      CLS_LHI,
      CLS_LW,
      CLS_SW,
      CLS_BEQ,
      CLS_JAL,
      CLS_ILL
   } iclass_e;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_ADI = 4'b0001;
   localparam logic [3:0] OP_NDU = 4'b0010;
   localparam logic [3:0] OP_LHI = 4'b0011;
   localparam logic [3:0] OP_LW  = 4'b0100;
   localparam logic [3:0] OP_SW  = 4'b0101;
   localparam logic [3:0] OP_JAL = 4'b1000;
   localparam logic [3:0] OP_BEQ = 4'b1100;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_NAND  = 2'd1;
   localparam logic [1:0] ALU_SUB   = 2'd2;
   localparam logic [1:0] ALU_PASSB = 2'd3;

   localparam logic [1:0] PC_INC = 2'd0;
   localparam logic [1:0] PC_IMM = 2'd1;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC  = 2'd2;
   localparam logic [1:0] WB_LHI = 2'd3;

   localparam logic ADDR_PC  = 1'b0;
   localparam logic ADDR_ALU = 1'b1;

   localparam int FLAG_C = 1;
   localparam int FLAG_Z = 0;

   // Instructions whose writeback also updates the carry/zero flags.
   function automatic logic writes_flags(iclass_e cls);
      return (cls == CLS_ADD) || (cls == CLS_NDU) || (cls == CLS_ADI);
   endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath/memory signal bundle for mc_ctrl.
// master = controller side, slave = datapath side.
interface mc_ctrl_if;
   logic [15:0] instr;
   logic [1:0]  flags;
   logic        alu_zero;
   logic        mem_ready;
   logic        mem_req;
   logic        mem_we;
   logic        addr_sel;
   logic        ir_we;
   logic        pc_we;
   logic        rf_we;
   logic        flag_we;
   logic [1:0]  pc_sel;
   logic [1:0]  alu_op;
   logic        alu_b_sel;
   logic [1:0]  wb_sel;
   logic        illegal;
   logic        timeout;
   logic        busy;

   modport master (
      input  instr, flags, alu_zero, mem_ready,
      output mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we, flag_we,
             pc_sel, alu_op, alu_b_sel, wb_sel, illegal, timeout, busy
   );

   modport slave (
      output instr, flags, alu_zero, mem_ready,
      input  mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we, flag_we,
             pc_sel, alu_op, alu_b_sel, wb_sel, illegal, timeout, busy
   );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode classifier with condition evaluation.
// Condition codes are honoured only when MC_CTRL_COND_EXEC_EN is defined.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic [1:0] cond,
   input  logic [1:0] flags,
   output iclass_e    iclass,
   output logic       cond_pass,
   output logic       illegal
);

   always_comb begin
      iclass = CLS_ILL;
      case (opcode)
         OP_ADD:  iclass = CLS_ADD;
         OP_NDU:  iclass = CLS_NDU;
         OP_ADI:  iclass = CLS_ADI;
         OP_LHI:  iclass = CLS_LHI;
         OP_LW:   iclass = CLS_LW;
         OP_SW:   iclass = CLS_SW;
         OP_BEQ:  iclass = CLS_BEQ;
         OP_JAL:  iclass = CLS_JAL;
         default: iclass = CLS_ILL;
      endcase
      illegal = (iclass == CLS_ILL);
   end

`ifdef MC_CTRL_COND_EXEC_EN
   // Only ADD/NDU are conditional; 00 and 11 both mean "always".
   always_comb begin
      cond_pass = 1'b1;
      if ((iclass == CLS_ADD) || (iclass == CLS_NDU)) begin
         case (cond)
            2'b10:   cond_pass = flags[FLAG_C];
            2'b01:   cond_pass = flags[FLAG_Z];
            default: cond_pass = 1'b1;
         endcase
      end
   end
`else
   logic unused_cond_inputs;
   assign unused_cond_inputs = ^{cond, flags};
   assign cond_pass = 1'b1;
`endif

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM for the 16-bit RISC datapath: state sequencing,
// memory wait watchdog and output decode. Option macro: MC_CTRL_COND_EXEC_EN.
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   mc_ctrl_if.master  bus
);

   localparam int CNT_W = $clog2(MEM_WAIT_MAX + 2);
   localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_WAIT_MAX);

   state_e           state_reg;
   logic [CNT_W-1:0] wait_cnt_reg;
   logic [CNT_W-1:0] wait_cnt_next;
   logic             timeout_reg;
   iclass_e          iclass;
   logic             cond_pass;
   logic             dec_illegal;
   logic             waiting;
   logic             unused_instr_bits;

   assign unused_instr_bits = ^bus.instr[11:2];

   mc_ctrl_decode u_decode (
      .opcode    (bus.instr[15:12]),
      .cond      (bus.instr[1:0]),
      .flags     (bus.flags),
      .iclass    (iclass),
      .cond_pass (cond_pass),
      .illegal   (dec_illegal)
   );

   assign waiting = ((state_reg == ST_FETCH) || (state_reg == ST_MEM)) && !bus.mem_ready;

   // Saturating count of back-to-back unanswered memory cycles.
   always_comb begin
      wait_cnt_next = '0;
      if (waiting) begin
         wait_cnt_next = (wait_cnt_reg == WAIT_LIMIT) ? wait_cnt_reg : wait_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_RST;
         wait_cnt_reg <= '0;
         timeout_reg  <= 1'b0;
      end else begin
         wait_cnt_reg <= wait_cnt_next;
         if (waiting && (wait_cnt_next == WAIT_LIMIT)) begin
            timeout_reg <= 1'b1;
         end
         case (state_reg)
            ST_RST:    state_reg <= ST_FETCH;
            ST_FETCH:  if (bus.mem_ready) state_reg <= ST_DECODE;
            ST_DECODE: begin
               if ((iclass == CLS_ILL) || (iclass == CLS_JAL)) state_reg <= ST_FETCH;
               else                                            state_reg <= ST_EXEC;
            end
            ST_EXEC: begin
               case (iclass)
                  CLS_LW, CLS_SW:   state_reg <= ST_MEM;
                  CLS_BEQ:          state_reg <= bus.alu_zero ? ST_BRANCH : ST_FETCH;
                  CLS_ADD, CLS_NDU: state_reg <= cond_pass ? ST_WB : ST_FETCH;
                  default:          state_reg <= ST_WB;
               endcase
            end
            ST_MEM: begin
               if (bus.mem_ready) state_reg <= (iclass == CLS_LW) ? ST_WB : ST_FETCH;
            end
            ST_WB:     state_reg <= ST_FETCH;
            ST_BRANCH: state_reg <= ST_FETCH;
            default:   state_reg <= ST_RST;
         endcase
      end
   end

   // FETCH/MEM enables follow mem_ready directly so a ready cycle completes the access.
   always_comb begin
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.addr_sel  = ADDR_PC;
      bus.ir_we     = 1'b0;
      bus.pc_we     = 1'b0;
      bus.rf_we     = 1'b0;
      bus.flag_we   = 1'b0;
      bus.pc_sel    = PC_INC;
      bus.alu_op    = ALU_ADD;
      bus.alu_b_sel = 1'b0;
      bus.wb_sel    = WB_ALU;
      bus.illegal   = 1'b0;
      case (state_reg)
         ST_FETCH: begin
            bus.mem_req = 1'b1;
            if (bus.mem_ready) begin
               bus.ir_we = 1'b1;
               bus.pc_we = 1'b1;
            end
         end
         ST_DECODE: begin
            bus.illegal = dec_illegal;
            if (iclass == CLS_JAL) begin
               bus.rf_we  = 1'b1;
               bus.wb_sel = WB_PC;
               bus.pc_we  = 1'b1;
               bus.pc_sel = PC_IMM;
            end
         end
         ST_EXEC: begin
            case (iclass)
               CLS_NDU:                 bus.alu_op = ALU_NAND;
               CLS_ADI, CLS_LW, CLS_SW: bus.alu_b_sel = 1'b1;
               CLS_LHI:                 bus.alu_op = ALU_PASSB;
               CLS_BEQ:                 bus.alu_op = ALU_SUB;
               default:                 bus.alu_op = ALU_ADD;
            endcase
         end
         ST_MEM: begin
            bus.mem_req  = 1'b1;
            bus.addr_sel = ADDR_ALU;
            bus.mem_we   = (iclass == CLS_SW);
         end
         ST_WB: begin
            bus.rf_we   = 1'b1;
            bus.flag_we = writes_flags(iclass);
            if (iclass == CLS_LW)       bus.wb_sel = WB_MEM;
            else if (iclass == CLS_LHI) bus.wb_sel = WB_LHI;
            else                        bus.wb_sel = WB_ALU;
         end
         ST_BRANCH: begin
            bus.pc_we  = 1'b1;
            bus.pc_sel = PC_IMM;
         end
         default: ;
      endcase
   end

   assign bus.timeout = timeout_reg;
   assign bus.busy    = (state_reg != ST_RST);

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: latency/event table, randomized phase-level
// reference model, and hand sequences for timeout and asynchronous reset.
module tb_mc_ctrl;
   import mc_ctrl_pkg::*;

`ifdef MC_CTRL_COND_EXEC_EN
   localparam bit COND_EN = 1'b1;
`else
   localparam bit COND_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mc_ctrl_if bus ();

   mc_ctrl #(.MEM_WAIT_MAX(15)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       addr_sel;
      logic       ir_we;
      logic       pc_we;
      logic       rf_we;
      logic       flag_we;
      logic [1:0] pc_sel;
      logic [1:0] alu_op;
      logic       alu_b_sel;
      logic [1:0] wb_sel;
      logic       illegal;
      logic       busy;
      logic       timeout;
   } out_t;

   typedef struct {
      logic  rdy;
      out_t  exp;
   } cyc_t;

   typedef struct {
      logic [15:0] ins;
      logic [1:0]  fl;
      logic        az;
      int          fw;
      int          mw;
      int          lat;
      int          n_rf;
      int          n_flag;
      int          wbs;
      int          n_pc;
      int          n_ill;
      int          n_req;
      int          n_we;
   } vec_t;

   int   vectors     = 0;
   int   miscompares = 0;
   cyc_t trace[$];
   logic [3:0] legal_ops [8] = '{OP_ADD, OP_NDU, OP_ADI, OP_LHI, OP_LW, OP_SW, OP_BEQ, OP_JAL};

   function automatic out_t sample_out();
      out_t o;
      o.mem_req   = bus.mem_req;
      o.mem_we    = bus.mem_we;
      o.addr_sel  = bus.addr_sel;
      o.ir_we     = bus.ir_we;
      o.pc_we     = bus.pc_we;
      o.rf_we     = bus.rf_we;
      o.flag_we   = bus.flag_we;
      o.pc_sel    = bus.pc_sel;
      o.alu_op    = bus.alu_op;
      o.alu_b_sel = bus.alu_b_sel;
      o.wb_sel    = bus.wb_sel;
      o.illegal   = bus.illegal;
      o.busy      = bus.busy;
      o.timeout   = bus.timeout;
      return o;
   endfunction

   task automatic check_out(input string name, input out_t act, input out_t exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: outputs=%05h expected=%05h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int idx, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // ---------------- reference model: instruction -> per-cycle expectations
   function automatic bit is_legal(input logic [3:0] op);
      for (int i = 0; i < 8; i++) if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit cond_ok(input logic [15:0] ins, input logic [1:0] fl);
      if (!COND_EN) return 1'b1;
      if ((ins[15:12] != OP_ADD) && (ins[15:12] != OP_NDU)) return 1'b1;
      if (ins[1:0] == 2'b10) return fl[1];
      if (ins[1:0] == 2'b01) return fl[0];
      return 1'b1;
   endfunction

   task automatic push(input logic rdy, input out_t o);
      cyc_t c;
      c.rdy = rdy;
      c.exp = o;
      trace.push_back(c);
   endtask

   task automatic push_any(input out_t o);
      push(1'($urandom), o);
   endtask

   task automatic gen_trace(input logic [15:0] ins, input logic [1:0] fl, input logic az,
                            input int fw, input int mw);
      out_t base, o;
      logic [3:0] op;
      op = ins[15:12];
      base = '0;
      base.busy = 1'b1;
      o = base; o.mem_req = 1'b1;
      for (int i = 0; i < fw; i++) push(1'b0, o);
      o.ir_we = 1'b1; o.pc_we = 1'b1;
      push(1'b1, o);
      if (!is_legal(op)) begin
         o = base; o.illegal = 1'b1; push_any(o);
         return;
      end
      if (op == OP_JAL) begin
         o = base; o.rf_we = 1'b1; o.wb_sel = 2'd2; o.pc_we = 1'b1; o.pc_sel = 2'd1;
         push_any(o);
         return;
      end
      push_any(base);
      o = base;
      if (op == OP_NDU) o.alu_op = 2'd1;
      if (op == OP_LHI) o.alu_op = 2'd3;
      if (op == OP_BEQ) o.alu_op = 2'd2;
      if (op == OP_ADI || op == OP_LW || op == OP_SW) o.alu_b_sel = 1'b1;
      push_any(o);
      if (op == OP_BEQ) begin
         if (az) begin
            o = base; o.pc_we = 1'b1; o.pc_sel = 2'd1; push_any(o);
         end
         return;
      end
      if (op == OP_LW || op == OP_SW) begin
         o = base; o.mem_req = 1'b1; o.addr_sel = 1'b1; o.mem_we = (op == OP_SW);
         for (int i = 0; i < mw; i++) push(1'b0, o);
         push(1'b1, o);
         if (op == OP_SW) return;
      end
      if (!cond_ok(ins, fl)) return;
      o = base; o.rf_we = 1'b1;
      o.wb_sel  = (op == OP_LW) ? 2'd1 : (op == OP_LHI) ? 2'd3 : 2'd0;
      o.flag_we = (op == OP_ADD) || (op == OP_ADI) || (op == OP_NDU);
      push_any(o);
   endtask

   task automatic play();
      for (int i = 0; i < trace.size(); i++) begin
         bus.mem_ready = trace[i].rdy;
         @(negedge clk);
         check_out($sformatf("cycle %0d ins=%04h", i, bus.instr), sample_out(), trace[i].exp);
         @(posedge clk); #1;
      end
   endtask

   // ---------------- table runner: reacts to mem_req and measures events
   task automatic run_vec(input int idx, input vec_t v);
      int cyc = 0, fcnt = 0, mcnt = 0;
      int n_rf = 0, n_flag = 0, n_pc = 0, n_ill = 0, n_req = 0, n_we = 0, wbs = -1;
      bit fetched = 1'b0, done = 1'b0;
      bus.instr    = v.ins;
      bus.flags    = v.fl;
      bus.alu_zero = v.az;
      while (cyc < 64 && !done) begin
         if (bus.mem_req && !bus.addr_sel && fetched) begin
            done = 1'b1;
         end else begin
            if (bus.mem_req && !bus.addr_sel) begin
               bus.mem_ready = (fcnt >= v.fw); fcnt++;
            end else if (bus.mem_req) begin
               bus.mem_ready = (mcnt >= v.mw); mcnt++;
            end else begin
               bus.mem_ready = 1'($urandom);
            end
            @(negedge clk);
            if (bus.ir_we) fetched = 1'b1;
            if (bus.rf_we) begin n_rf++; wbs = int'(bus.wb_sel); end
            if (bus.flag_we) n_flag++;
            if (bus.pc_we) n_pc++;
            if (bus.illegal) n_ill++;
            if (bus.mem_req) n_req++;
            if (bus.mem_we) n_we++;
            cyc++;
            @(posedge clk); #1;
         end
      end
      check_int("completed", idx, int'(done), 1);
      check_int("latency", idx, cyc, v.lat);
      check_int("rf_we_cycles", idx, n_rf, v.n_rf);
      check_int("flag_we_cycles", idx, n_flag, v.n_flag);
      check_int("wb_sel", idx, wbs, v.wbs);
      check_int("pc_we_cycles", idx, n_pc, v.n_pc);
      check_int("illegal_cycles", idx, n_ill, v.n_ill);
      check_int("mem_req_cycles", idx, n_req, v.n_req);
      check_int("mem_we_cycles", idx, n_we, v.n_we);
      $display("vec %0d ins=%04h lat=%0d rf=%0d flag=%0d pc=%0d req=%0d", idx, v.ins, cyc, n_rf, n_flag, n_pc, n_req);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [15];
      logic [15:0] ins;
      logic [3:0]  op;
      logic [1:0]  fl;
      logic        az;
      int          fw, mw, pick;

      //         ins       fl     az    fw mw lat rf flag wbs pc ill req we
      tbl[0]  = '{16'h0000, 2'b00, 1'b0, 0, 0, 4, 1, 1, 0, 1, 0, 1, 0};
      tbl[1]  = '{16'h2000, 2'b00, 1'b0, 0, 0, 4, 1, 1, 0, 1, 0, 1, 0};
      tbl[2]  = '{16'h1000, 2'b00, 1'b0, 2, 0, 6, 1, 1, 0, 1, 0, 3, 0};
      tbl[3]  = '{16'h3000, 2'b00, 1'b0, 0, 0, 4, 1, 0, 3, 1, 0, 1, 0};
      tbl[4]  = '{16'h4000, 2'b00, 1'b0, 0, 3, 8, 1, 0, 1, 1, 0, 5, 0};
      tbl[5]  = '{16'h5000, 2'b00, 1'b0, 0, 1, 5, 0, 0, -1, 1, 0, 3, 2};
      tbl[6]  = '{16'hC000, 2'b00, 1'b1, 0, 0, 4, 0, 0, -1, 2, 0, 1, 0};
      tbl[7]  = '{16'hC000, 2'b00, 1'b0, 0, 0, 3, 0, 0, -1, 1, 0, 1, 0};
      tbl[8]  = '{16'h8000, 2'b00, 1'b0, 0, 0, 2, 1, 0, 2, 2, 0, 1, 0};
      tbl[9]  = '{16'hF000, 2'b00, 1'b0, 0, 0, 2, 0, 0, -1, 1, 1, 1, 0};
      tbl[10] = '{16'h6000, 2'b00, 1'b0, 1, 0, 3, 0, 0, -1, 1, 1, 2, 0};
      tbl[11] = COND_EN ? '{16'h0002, 2'b00, 1'b0, 0, 0, 3, 0, 0, -1, 1, 0, 1, 0}
                        : '{16'h0002, 2'b00, 1'b0, 0, 0, 4, 1, 1, 0, 1, 0, 1, 0};
      tbl[12] = '{16'h0002, 2'b10, 1'b0, 0, 0, 4, 1, 1, 0, 1, 0, 1, 0};
      tbl[13] = COND_EN ? '{16'h2001, 2'b10, 1'b0, 0, 0, 3, 0, 0, -1, 1, 0, 1, 0}
                        : '{16'h2001, 2'b10, 1'b0, 0, 0, 4, 1, 1, 0, 1, 0, 1, 0};
      tbl[14] = '{16'h0003, 2'b00, 1'b0, 0, 0, 4, 1, 1, 0, 1, 0, 1, 0};

      // Reset: everything idle, then one RST cycle before FETCH.
      rst_n         = 1'b0;
      bus.instr     = 16'h0000;
      bus.flags     = 2'b00;
      bus.alu_zero  = 1'b0;
      bus.mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_out("reset_held", sample_out(), '0);
      rst_n = 1'b1;
      #1;
      check_out("rst_state", sample_out(), '0);
      @(posedge clk); #1;

      for (int i = 0; i < 15; i++) run_vec(i, tbl[i]);

      for (int n = 0; n < 60; n++) begin
         pick = $urandom_range(0, 9);
         op   = (pick < 8) ? legal_ops[pick] : 4'($urandom);
         ins  = {op, 12'($urandom)};
         fl   = 2'($urandom);
         az   = 1'($urandom);
         fw   = $urandom_range(0, 3);
         mw   = $urandom_range(0, 3);
         trace.delete();
         gen_trace(ins, fl, az, fw, mw);
         bus.instr    = ins;
         bus.flags    = fl;
         bus.alu_zero = az;
         play();
         $display("rand %0d ins=%04h fl=%b az=%b fw=%0d mw=%0d cycles=%0d", n, ins, fl, az, fw, mw, trace.size());
      end

      // Fetch stall: timeout appears after the 15th unanswered cycle and sticks.
      bus.mem_ready = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         check_bit($sformatf("timeout_wait%0d", i), bus.timeout, (i == 16));
         check_bit($sformatf("mem_req_hold%0d", i), bus.mem_req, 1'b1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check_bit("timeout_sticky", bus.timeout, 1'b1);
      $display("timeout sequence timeout=%b", bus.timeout);

      // Asynchronous reset in the middle of the stalled fetch.
      rst_n = 1'b0;
      #1;
      check_bit("async_mem_req", bus.mem_req, 1'b0);
      check_bit("async_timeout", bus.timeout, 1'b0);
      check_bit("async_busy", bus.busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.mem_ready = 1'b1;
      #1;
      check_bit("post_rst_busy", bus.busy, 1'b0);
      @(posedge clk); #1;
      check_bit("post_rst_fetch_req", bus.mem_req, 1'b1);
      check_bit("post_rst_timeout", bus.timeout, 1'b0);
      $display("reset sequence busy=%b mem_req=%b", bus.busy, bus.mem_req);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
